// File: rtl/regfile_wb_ctrl.sv
// Writeback controller for the integer register file.
// Arbitrates ALU/LSU results, stages the write, tracks busy regs, forwards.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module regfile_wb_ctrl #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  alu_valid_i,
    input  logic [4:0]            alu_rd_i,
    input  logic [DATA_WIDTH-1:0] alu_data_i,
    output logic                  alu_ready_o,
    input  logic                  lsu_valid_i,
    input  logic [4:0]            lsu_rd_i,
    input  logic [DATA_WIDTH-1:0] lsu_data_i,
    output logic                  lsu_ready_o,
    input  logic                  issue_valid_i,
    input  logic [4:0]            issue_rd_i,
    output logic [31:0]           busy_o,
    output logic [4:0]            w_addr_o,
    output logic [DATA_WIDTH-1:0] dout_o,
    input  logic [4:0]            r1_addr_i,
    input  logic [4:0]            r2_addr_i,
    output logic                  fwd1_hit_o,
    output logic [DATA_WIDTH-1:0] fwd1_data_o,
    output logic                  fwd2_hit_o,
    output logic [DATA_WIDTH-1:0] fwd2_data_o
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0]         starve_cnt;
    logic                  starved;
    logic                  alu_win;
    logic                  lsu_win;
    logic                  accept;
    logic [4:0]            win_rd;
    logic [DATA_WIDTH-1:0] win_data;
    logic [31:0]           set_mask;
    logic [31:0]           clr_mask;

    // Pick one winner: LSU by default, ALU once it has lost too often
    always_comb begin
        starved  = (starve_cnt == CW'(STARVE_MAX));
        alu_win  = alu_valid_i & (~lsu_valid_i | starved);
        lsu_win  = lsu_valid_i & ~alu_win;
        accept   = alu_win | lsu_win;
        win_rd   = alu_win ? alu_rd_i : lsu_rd_i;
        win_data = alu_win ? alu_data_i : lsu_data_i;
    end

    assign alu_ready_o = alu_win;
    assign lsu_ready_o = lsu_win;

    // Count consecutive ALU losses against a valid LSU result
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_cnt <= '0;
        end else if (!alu_valid_i || alu_win) begin
            starve_cnt <= '0;
        end else if (lsu_win && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Stage the winner for one cycle; idle cycles present address 0
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            w_addr_o <= '0;
            dout_o   <= '0;
        end else if (accept) begin
            w_addr_o <= win_rd;
            dout_o   <= win_data;
        end else begin
            w_addr_o <= '0;
        end
    end

    // Issue sets and the committing write clears; x0 never counts
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid_i && issue_rd_i != 5'd0) begin
            set_mask = 32'd1 << issue_rd_i;
        end
        if (w_addr_o != 5'd0) begin
            clr_mask = 32'd1 << w_addr_o;
        end
    end

    // Busy scoreboard; a set on the clearing edge keeps the bit high
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_o <= '0;
        end else begin
            busy_o <= ((busy_o & ~clr_mask) | set_mask) & ~32'd1;
        end
    end

    // Forward the staged write to both read ports
    always_comb begin
        fwd1_hit_o  = (r1_addr_i != 5'd0) && (r1_addr_i == w_addr_o);
        fwd2_hit_o  = (r2_addr_i != 5'd0) && (r2_addr_i == w_addr_o);
        fwd1_data_o = dout_o;
        fwd2_data_o = dout_o;
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed stimulus, staged writes
// checked against a queue of expected {rd, data} entries.
`timescale 1ns/1ps

module tb_regfile_wb_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid;
    logic [4:0]    alu_rd;
    logic [DW-1:0] alu_data;
    logic          alu_ready;
    logic          lsu_valid;
    logic [4:0]    lsu_rd;
    logic [DW-1:0] lsu_data;
    logic          lsu_ready;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic [31:0]   busy;
    logic [4:0]    w_addr;
    logic [DW-1:0] dout;
    logic [4:0]    r1_addr;
    logic [4:0]    r2_addr;
    logic          fwd1_hit;
    logic [DW-1:0] fwd1_data;
    logic          fwd2_hit;
    logic [DW-1:0] fwd2_data;

    int n_cmp = 0;
    int n_bad = 0;
    logic [4+DW:0] exp_q[$];

    regfile_wb_ctrl #(.DATA_WIDTH(DW), .STARVE_MAX(4)) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .alu_valid_i(alu_valid),
        .alu_rd_i(alu_rd),
        .alu_data_i(alu_data),
        .alu_ready_o(alu_ready),
        .lsu_valid_i(lsu_valid),
        .lsu_rd_i(lsu_rd),
        .lsu_data_i(lsu_data),
        .lsu_ready_o(lsu_ready),
        .issue_valid_i(issue_valid),
        .issue_rd_i(issue_rd),
        .busy_o(busy),
        .w_addr_o(w_addr),
        .dout_o(dout),
        .r1_addr_i(r1_addr),
        .r2_addr_i(r2_addr),
        .fwd1_hit_o(fwd1_hit),
        .fwd1_data_o(fwd1_data),
        .fwd2_hit_o(fwd2_hit),
        .fwd2_data_o(fwd2_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [DW-1:0] d);
        exp_q.push_back({rd, d});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every staged nonzero write must match the next expected entry
    always @(negedge clk) begin
        if (rst_n && w_addr != 5'd0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL wb_unexpected: got rd=%0d data=%0h",
                         w_addr, dout);
            end else begin
                logic [4+DW:0] e;
                e = exp_q.pop_front();
                if ({w_addr, dout} !== e) begin
                    n_bad++;
                    $display("FAIL wb_stream: got rd=%0d data=%0h expected rd=%0d data=%0h",
                             w_addr, dout, e[4+DW:DW], e[DW-1:0]);
                end
            end
        end
    end

    initial begin
        int k;
        logic exp_alu;
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        r1_addr = 5'd5; r2_addr = 5'd5;

        #2;
        chk("rst_w_addr", 64'(w_addr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_alu_ready", 64'(alu_ready), 64'd0);
        chk("rst_lsu_ready", 64'(lsu_ready), 64'd0);
        chk("rst_fwd1_hit", 64'(fwd1_hit), 64'd0);
        chk("rst_fwd2_hit", 64'(fwd2_hit), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // single ALU result, one cycle latency
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h2A;
        push(5'd5, 32'h2A);
        @(negedge clk);
        chk("alu_ready_single", 64'(alu_ready), 64'd1);
        chk("lsu_ready_single", 64'(lsu_ready), 64'd0);
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("stage_addr_n1", 64'(w_addr), 64'd5);
        chk("stage_data_n1", 64'(dout), 64'h2A);
        step();
        @(negedge clk);
        chk("stage_addr_n2", 64'(w_addr), 64'd0);
        step();

        // contention: LSU wins four, ALU wins the fifth
        k = 0;
        for (int i = 0; i < 10; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100 + k;
            lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h200 + i;
            exp_alu = (i % 5 == 4);
            if (exp_alu) push(5'd1, 32'h100 + k);
            else push(5'd2, 32'h200 + i);
            @(negedge clk);
            chk($sformatf("arb_alu_%0d", i), 64'(alu_ready), 64'(exp_alu));
            chk($sformatf("arb_lsu_%0d", i), 64'(lsu_ready), 64'(!exp_alu));
            step();
            if (exp_alu) k++;
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        step();

        // scoreboard set / clear / set-wins
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("busy_set7", 64'(busy), 64'h80);
        step();
        step();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        push(5'd7, 32'h77);
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("busy_staged7", 64'(busy), 64'h80);
        step();
        @(negedge clk);
        chk("busy_clr7", 64'(busy), 64'h0);
        step();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h78;
        push(5'd7, 32'h78);
        step();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("busy_set_wins", 64'(busy), 64'h80);
        issue_valid = 1'b1; issue_rd = 5'd0;
        step();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("busy_x0", 64'(busy), 64'h80);
        step();

        // forwarding from the staged write
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h99;
        push(5'd3, 32'h99);
        r1_addr = 5'd3; r2_addr = 5'd0;
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("fwd1_hit", 64'(fwd1_hit), 64'd1);
        chk("fwd1_data", 64'(fwd1_data), 64'h99);
        chk("fwd2_hit_x0", 64'(fwd2_hit), 64'd0);
        r2_addr = 5'd3;
        #1;
        chk("fwd2_hit", 64'(fwd2_hit), 64'd1);
        chk("fwd2_data", 64'(fwd2_data), 64'h99);
        step();
        @(negedge clk);
        chk("fwd1_hit_gone", 64'(fwd1_hit), 64'd0);
        step();

        // rd=0 result is accepted but not written
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
        @(negedge clk);
        chk("rd0_ready", 64'(alu_ready), 64'd1);
        step();
        alu_valid = 1'b0;
        @(negedge clk);
        chk("rd0_no_write", 64'(w_addr), 64'd0);
        step();

        // build starve count, stage a write, then reset mid-flight
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd0;
            lsu_valid = 1'b1; lsu_rd = 5'd0;
            step();
        end
        lsu_rd = 5'd9; lsu_data = 32'h31;
        issue_valid = 1'b1; issue_rd = 5'd12;
        @(negedge clk);
        chk("pre_rst_lsu_ready", 64'(lsu_ready), 64'd1);
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
        chk("pre_rst_w_addr", 64'(w_addr), 64'd9);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_w_addr", 64'(w_addr), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        lsu_rd = 5'd0;
        for (int i = 0; i < 5; i++) begin
            alu_valid = 1'b1; lsu_valid = 1'b1;
            exp_alu = (i == 4);
            @(negedge clk);
            chk($sformatf("post_rst_arb_%0d", i), 64'(alu_ready),
                64'(exp_alu));
            step();
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        step();
        @(negedge clk);
        chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
